booth_mult_sequencer: RTL
=========================

# booth_mult_sequencer

Upstream issue/collect stage for the 4-bit sequential Booth multiplier. Buffers signed operand pairs from a valid/ready producer, issues each pair to the multiplier with a one-cycle start pulse, tracks the multiplier's busy line, captures the 8-bit product and presents it on a valid/ready output. One multiplication in flight at a time; a watchdog flags a multiplier that never completes.

## Interface
- DEPTH, 4: operand FIFO entries; power of 2, ≥2
- TIMEOUT, 15: maximum cycles spent waiting on the multiplier before abort; 4-bit counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO not full
- in_mc  in  4  multiplicand, two's complement
- in_mp  in  4  multiplier, two's complement
- out_valid  out  1  product held
- out_ready  in  1  consumer accepts
- out_prod  out  8  signed product
- mul_start  out  1  start pulse to multiplier
- mul_mc  out  4  registered multiplicand to multiplier
- mul_mp  out  4  registered multiplier to multiplier
- mul_busy  in  1  multiplier busy
- mul_prod  in  8  multiplier product
- err_timeout  out  1  sticky watchdog flag
- err_clr  in  1  clears err_timeout (and err_mismatch)

## Operation
- Reset values: in_ready=1, out_valid=0, out_prod=0, mul_start=0, mul_mc=0, mul_mp=0, err_timeout=0, FIFO empty, state IDLE, watchdog=0.
- FIFO push on in_valid&&in_ready. in_ready=!full, with no credit for a same-cycle pop.
- FSM:
  - IDLE: if FIFO non-empty → pop, load mul_mc/mul_mp, mul_start=1 → LOAD.
  - LOAD: mul_start=0 → WAIT_HI.
  - WAIT_HI: mul_busy==1 → WAIT_LO.
  - WAIT_LO: first sampled mul_busy==0 → out_prod<=mul_prod, out_valid=1 → HOLD.
  - HOLD: out_ready → out_valid=0 → IDLE.
- mul_busy falls for exactly one cycle, then the multiplier free-runs again. WAIT_LO must capture on that cycle. mul_busy is ignored outside WAIT_HI/WAIT_LO, so its pre-first-start X value is harmless.
- Watchdog:
  - Clears on LOAD entry; increments each cycle in WAIT_HI/WAIT_LO.
  - When it reaches TIMEOUT: err_timeout=1, operation dropped, no output produced → IDLE.
- err_clr clears the error flags next edge. If err_clr and a new timeout occur in the same cycle, the set wins.
- Product is passed through unmodified; the sequencer performs no arithmetic except the optional check.

## Timing
- Edge E0 (IDLE pop): mul_start high during E0→E1. The multiplier loads at E1.
- Multiplier busy is high from E2. Product and busy-low at E6. The sequencer captures at E7; out_valid is high after E7.
- Accept-to-out_valid latency with an empty pipeline: 8 cycles (push edge + pop edge + 6).
- Back-to-back issue: next pop earliest one cycle after out handshake. Throughput 1 product / 9 cycles with out_ready tied high.
- Reset mid-operation: all state returns to reset values immediately. FIFO contents are lost. mul_start goes low asynchronously.

## Configuration
- BOOTH_SEQ_CHECK_EN defined:
  - adds output err_mismatch (1 bit, sticky, reset 0, cleared by err_clr);
  - the captured product is compared with the signed product $signed(mul_mc)*$signed(mul_mp) computed combinationally at capture;
  - a mismatch sets err_mismatch; out_prod is still delivered.
- Undefined: no port, no comparator.

## Structure
- Package booth_seq_pkg: state enum (IDLE, LOAD, WAIT_HI, WAIT_LO, HOLD), OPW=4, PRODW=8, watchdog width constant.
- Sub-module booth_seq_fifo:
  - parameterised DEPTH × 8-bit synchronous FIFO with full/empty;
  - pointers one bit wider than the address for wrap detection;
  - same clock and reset.

## Test plan
- Single op: mc=4'h3, mp=4'hE (3×−2), bench model of the multiplier → out_prod=8'hFA, out_valid 8 cycles after push, err_timeout=0.
- Burst of 4 pairs {(7,8),(2,3),(F,F),(5,0)}, out_ready=1 → products in order: 8'hC8, 8'h06, 8'h01, 8'h00.
- Backpressure: out_ready=0, push 6 pairs → in_ready low after 5 accepted (4 FIFO + 1 in flight). Release → all 5 delivered in order.
- Watchdog: mul_busy tied 0 → err_timeout=1 at TIMEOUT cycles after LOAD, out_valid stays 0, FSM in IDLE. err_clr pulse → flag 0.
- Reset mid-op: assert rst_n=0 in WAIT_HI → all outputs at reset values same cycle. A fresh op after release completes correctly.
- With BOOTH_SEQ_CHECK_EN: multiplier model returns 8'h00 for (3,3) → err_mismatch=1, out_prod=8'h00 delivered.

Source files
------------

// File: rtl/booth_seq_pkg.sv
// Shared constants, state encoding, operand payload and reference product
// for the Booth multiplier issue/collect sequencer.
package booth_seq_pkg;

  localparam int unsigned OPW   = 4;  // operand width
  localparam int unsigned PRODW = 8;  // product width
  localparam int unsigned WDW   = 4;  // watchdog counter width
  localparam int unsigned STW   = 3;  // state register width

  // Sequencer states
  localparam logic [STW-1:0] ST_IDLE    = 3'd0;
  localparam logic [STW-1:0] ST_LOAD    = 3'd1;
  localparam logic [STW-1:0] ST_WAIT_HI = 3'd2;
  localparam logic [STW-1:0] ST_WAIT_LO = 3'd3;
  localparam logic [STW-1:0] ST_HOLD    = 3'd4;

  // Operand pair as stored in the FIFO
  typedef struct packed {
    logic [OPW-1:0] mc;
    logic [OPW-1:0] mp;
  } op_pair_t;

  localparam int unsigned PAIRW = $bits(op_pair_t);

  // Two's complement product of two operands, used by the optional checker
  function automatic logic [PRODW-1:0] signed_prod(input logic [OPW-1:0] a,
                                                   input logic [OPW-1:0] b);
    logic signed [PRODW-1:0] sa;
    logic signed [PRODW-1:0] sb;
    sa = $signed({{(PRODW-OPW){a[OPW-1]}}, a});
    sb = $signed({{(PRODW-OPW){b[OPW-1]}}, b});
    return PRODW'(sa * sb);
  endfunction

endpackage

// File: rtl/booth_seq_fifo.sv
// Synchronous first-word-fall-through FIFO holding operand pairs.
// Ports: clk/rst_n; push/wdata write side; pop/rdata read side;
// full/empty status. Pointers carry one extra bit to tell full from empty.
module booth_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  // Status from pointer comparison
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rdata = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointer / storage values; guarded against overflow and underflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Issue/collect stage for the 4-bit sequential Booth multiplier.
// Buffers operand pairs (in_valid/in_ready, in_mc/in_mp), issues one at a
// time with a start pulse (mul_start, mul_mc, mul_mp), waits for the busy
// line to rise then fall (mul_busy), captures mul_prod and presents it on
// out_valid/out_ready/out_prod. A watchdog aborts a stuck operation and sets
// the sticky err_timeout; err_clr clears error flags.
// Optional macro BOOTH_SEQ_CHECK_EN adds err_mismatch, a sticky flag set
// when the captured product differs from the signed product of the operands.
module booth_mult_sequencer
  import booth_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_mc,
  input  logic [3:0] in_mp,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_prod,
  output logic       mul_start,
  output logic [3:0] mul_mc,
  output logic [3:0] mul_mp,
  input  logic       mul_busy,
  input  logic [7:0] mul_prod,
  output logic       err_timeout,
`ifdef BOOTH_SEQ_CHECK_EN
  output logic       err_mismatch,
`endif
  input  logic       err_clr
);

  logic [STW-1:0]   state_q, state_d;
  logic [OPW-1:0]   mc_q, mc_d;
  logic [OPW-1:0]   mp_q, mp_d;
  logic             start_q, start_d;
  logic [PRODW-1:0] prod_q, prod_d;
  logic             out_valid_q, out_valid_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [WDW-1:0]   wdog_inc;
  logic             err_to_q, err_to_d;
`ifdef BOOTH_SEQ_CHECK_EN
  logic             err_mm_q, err_mm_d;
`endif

  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;
  op_pair_t fifo_wdata;
  op_pair_t fifo_rdata;

  assign fifo_wdata = '{mc: in_mc, mp: in_mp};

  booth_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (PAIRW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // No credit for a same-cycle pop: ready depends only on current occupancy
  assign in_ready    = !fifo_full;
  assign out_valid   = out_valid_q;
  assign out_prod    = prod_q;
  assign mul_start   = start_q;
  assign mul_mc      = mc_q;
  assign mul_mp      = mp_q;
  assign err_timeout = err_to_q;
`ifdef BOOTH_SEQ_CHECK_EN
  assign err_mismatch = err_mm_q;
`endif

  assign wdog_inc = wdog_q + WDW'(1);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
    start_d     = 1'b0;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    wdog_d      = wdog_q;
    fifo_pop    = 1'b0;
    err_to_d    = err_to_q && !err_clr;
`ifdef BOOTH_SEQ_CHECK_EN
    err_mm_d    = err_mm_q && !err_clr;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          mc_d     = fifo_rdata.mc;
          mp_d     = fifo_rdata.mp;
          start_d  = 1'b1;
          wdog_d   = '0;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI, ST_WAIT_LO: begin
        if (state_q == ST_WAIT_LO && !mul_busy) begin
          // Busy is low for a single cycle only; capture on this edge
          prod_d      = mul_prod;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
`ifdef BOOTH_SEQ_CHECK_EN
          if (signed_prod(mc_q, mp_q) != mul_prod) begin
            err_mm_d = 1'b1;
          end
`endif
        end else begin
          if (state_q == ST_WAIT_HI && mul_busy) begin
            state_d = ST_WAIT_LO;
          end
          wdog_d = wdog_inc;
          // Abort drops the operation; a new timeout wins over err_clr
          if (wdog_inc == WDW'(TIMEOUT)) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mc_q        <= '0;
      mp_q        <= '0;
      start_q     <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      wdog_q      <= '0;
      err_to_q    <= 1'b0;
`ifdef BOOTH_SEQ_CHECK_EN
      err_mm_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      start_q     <= start_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      wdog_q      <= wdog_d;
      err_to_q    <= err_to_d;
`ifdef BOOTH_SEQ_CHECK_EN
      err_mm_q    <= err_mm_d;
`endif
    end
  end

endmodule
